// File: rtl/framing_controller.sv
// Symbol-multiplexer sequencer: frames TLP bursts (STP, data, END/EDB), inserts
// COM+SKP x3 skip ordered sets at a fixed interval and idles the channel on IDL.
module framing_controller #(
  parameter int unsigned SKP_INTERVAL = 32
) (
  input  logic       ctrlCLK,
  input  logic       ctrlRSTn,
  input  logic       ctrlEN,
  input  logic       tlpREQ,
  input  logic [3:0] tlpLEN,
  input  logic       tlpABORT,
  output logic       tlpACK,
  output logic       tlpRD,
  output logic [3:0] muxCTRL,
  output logic       ENB,
  output logic       busy
);

  localparam logic [3:0] SymTlp = 4'b0000;
  localparam logic [3:0] SymCom = 4'b0001;
  localparam logic [3:0] SymSkp = 4'b0011;
  localparam logic [3:0] SymStp = 4'b0100;
  localparam logic [3:0] SymEnd = 4'b0110;
  localparam logic [3:0] SymEdb = 4'b0111;
  localparam logic [3:0] SymIdl = 4'b1001;

  localparam logic [7:0] SkpLast = 8'(SKP_INTERVAL - 1);

  typedef enum logic [2:0] {
    StOff,
    StIdle,
    StStp,
    StData,
    StEnd,
    StEdb,
    StSkc,
    StSks
  } state_e;

  state_e     state_q, state_d;
  state_e     decision;
  logic [3:0] rem_q, rem_d;
  logic [1:0] sks_q, sks_d;
  logic [7:0] skp_cnt_q, skp_cnt_d;
  logic       skp_pend_q, skp_pend_d;
  logic       terminal;

  logic [3:0] mux_d;
  logic       ack_d, rd_d, enb_d, busy_d;

  // Shared choice made at the end of IDLE, END, EDB and the last SKS cycle.
  always_comb begin
    decision = StIdle;
    if (!ctrlEN) begin
      decision = StOff;
    end else if (skp_pend_q) begin
      decision = StSkc;
    end else if (tlpREQ) begin
      decision = StStp;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    sks_d   = sks_q;
    unique case (state_q)
      StOff: begin
        if (ctrlEN) state_d = StIdle;
      end
      StIdle, StEnd, StEdb: begin
        state_d = decision;
      end
      StStp: begin
        state_d = ctrlEN ? StData : StEdb;
      end
      StData: begin
        rem_d = rem_q - 4'd1;
        if (!ctrlEN || tlpABORT) begin
          state_d = StEdb;
        end else if (rem_q == 4'd0) begin
          state_d = StEnd;
        end
      end
      StSkc: begin
        state_d = StSks;
        sks_d   = 2'd2;
      end
      StSks: begin
        if (sks_q == 2'd0) begin
          state_d = decision;
        end else begin
          sks_d = sks_q - 2'd1;
        end
      end
      default: state_d = StOff;
    endcase
    if (state_d == StStp) rem_d = tlpLEN;
  end

  // A terminal count on the edge that enters SKC starts a fresh pending request.
  always_comb begin
    terminal  = ENB && (skp_cnt_q == SkpLast);
    skp_cnt_d = skp_cnt_q;
    if (ENB) skp_cnt_d = terminal ? 8'd0 : skp_cnt_q + 8'd1;
    skp_pend_d = terminal | (skp_pend_q & (state_d != StSkc));
  end

  always_comb begin
    mux_d  = SymIdl;
    ack_d  = 1'b0;
    rd_d   = 1'b0;
    enb_d  = 1'b1;
    busy_d = 1'b1;
    unique case (state_d)
      StOff: begin
        enb_d  = 1'b0;
        busy_d = 1'b0;
      end
      StIdle: busy_d = 1'b0;
      StStp: begin
        mux_d = SymStp;
        ack_d = 1'b1;
      end
      StData: begin
        mux_d = SymTlp;
        rd_d  = 1'b1;
      end
      StEnd:   mux_d = SymEnd;
      StEdb:   mux_d = SymEdb;
      StSkc:   mux_d = SymCom;
      StSks:   mux_d = SymSkp;
      default: mux_d = SymIdl;
    endcase
  end

  always_ff @(posedge ctrlCLK or negedge ctrlRSTn) begin
    if (!ctrlRSTn) begin
      state_q    <= StOff;
      rem_q      <= 4'd0;
      sks_q      <= 2'd0;
      skp_cnt_q  <= 8'd0;
      skp_pend_q <= 1'b0;
      muxCTRL    <= SymIdl;
      ENB        <= 1'b0;
      tlpACK     <= 1'b0;
      tlpRD      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      sks_q      <= sks_d;
      skp_cnt_q  <= skp_cnt_d;
      skp_pend_q <= skp_pend_d;
      muxCTRL    <= mux_d;
      ENB        <= enb_d;
      tlpACK     <= ack_d;
      tlpRD      <= rd_d;
      busy       <= busy_d;
    end
  end

endmodule
